// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: free-running PC, one-cycle ROM read port and a small
// prefetch FIFO that absorbs decode stalls and is flushed on any redirect.
module ifu_prefetch #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter int                    PC_STEP    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic                  rom_req_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  idu_valid_o,
  input  logic                  idu_ready_i,
  output logic [DATA_WIDTH-1:0] idu_instr_o,
  output logic [ADDR_WIDTH-1:0] idu_addr_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]           DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflightAddr_q, inflightAddr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH-1:0] memAddr_q  [DEPTH];
  logic [DATA_WIDTH-1:0] memInstr_q [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   level;

  // The in-flight word already owns a FIFO slot, so a push can never overflow.
  assign level       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue       = !jump_en_i && (level < DEPTH_C);
  assign push        = inflight_q && !jump_en_i;
  assign idu_valid_o = (count_q != '0) && !jump_en_i;
  assign pop         = idu_valid_o && idu_ready_i;

  assign rom_req_o   = issue;
  assign rom_addr_o  = pc_q;
  assign idu_instr_o = memInstr_q[rdPtr_q];
  assign idu_addr_o  = memAddr_q[rdPtr_q];

  always_comb begin
    pc_d           = pc_q;
    inflight_d     = inflight_q;
    inflightAddr_d = inflightAddr_q;
    count_d        = count_q;
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    if (jump_en_i) begin
      pc_d       = jump_addr_i;
      inflight_d = 1'b0;
      count_d    = '0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d           = pc_q + STEP_C;
        inflightAddr_d = pc_q;
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_ADDR;
      inflight_q     <= 1'b0;
      inflightAddr_q <= '0;
      count_q        <= '0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        memAddr_q[i]  <= '0;
        memInstr_q[i] <= '0;
      end
    end else begin
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      inflightAddr_q <= inflightAddr_d;
      count_q        <= count_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      if (push) begin
        memAddr_q[wrPtr_q]  <= inflightAddr_q;
        memInstr_q[wrPtr_q] <= rom_data_i;
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: a 10-bit/DEPTH 4 unit plus a 6-bit unit
// for PC wrap, each fed by a one-cycle ROM returning addr ^ 32'hA5A5_0000.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jumpEn;
  logic [9:0]  jumpAddr;
  logic        ready;

  logic        romReq;
  logic [9:0]  romAddr;
  logic [31:0] romData;
  logic        valid;
  logic [31:0] instr;
  logic [9:0]  iduAddr;

  logic        romReq6;
  logic [5:0]  romAddr6;
  logic [31:0] romData6;
  logic        valid6;
  logic [31:0] instr6;
  logic [5:0]  iduAddr6;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  ifu_prefetch #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jumpEn), .jump_addr_i(jumpAddr),
    .rom_req_o(romReq), .rom_addr_o(romAddr), .rom_data_i(romData),
    .idu_valid_o(valid), .idu_ready_i(ready), .idu_instr_o(instr), .idu_addr_o(iduAddr)
  );

  ifu_prefetch #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_ADDR('0)) dut6 (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jumpEn), .jump_addr_i(jumpAddr[5:0]),
    .rom_req_o(romReq6), .rom_addr_o(romAddr6), .rom_data_i(romData6),
    .idu_valid_o(valid6), .idu_ready_i(ready), .idu_instr_o(instr6), .idu_addr_o(iduAddr6)
  );

  function automatic logic [31:0] expData(input logic [9:0] a);
    return {22'b0, a} ^ 32'hA5A5_0000;
  endfunction

  // ROM models answer one cycle after the address is presented
  always_ff @(posedge clk) begin
    romData  <= expData(romAddr);
    romData6 <= expData({4'b0, romAddr6});
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic j, input logic [9:0] a, input logic r);
    @(negedge clk);
    jumpEn   = j;
    jumpAddr = a;
    ready    = r;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n  = 1'b0;
    jumpEn = 1'b0;
    ready  = 1'b0;
    @(negedge clk);
  endtask

  // Releasing reset starts cycle 0
  task automatic releaseReset(input logic r);
    @(negedge clk);
    rst_n  = 1'b1;
    jumpEn = 1'b0;
    ready  = r;
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},   32'(romReq),  32'd1);
    checkOutput({tag, "_raddr"}, 32'(romAddr), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid),   32'd0);
    checkOutput({tag, "_instr"}, instr,        32'd0);
    checkOutput({tag, "_iaddr"}, 32'(iduAddr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] expNext;
    int         delivered;
    int         maxCount;
    logic       j;
    logic [9:0] a;
    logic       r;

    rst_n    = 1'b0;
    jumpEn   = 1'b0;
    jumpAddr = '0;
    ready    = 1'b0;
    #2;
    checkResetOutputs("reset");

    // Streaming with ready held high
    releaseReset(1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) applyStimulus(1'b0, 10'd0, 1'b1);
      checkOutput($sformatf("stream_req%0d", c),  32'(romReq),  32'd1);
      checkOutput($sformatf("stream_addr%0d", c), 32'(romAddr), 32'(4 * c));
      checkOutput($sformatf("stream_valid%0d", c), 32'(valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        checkOutput($sformatf("stream_iaddr%0d", c), 32'(iduAddr), 32'(4 * (c - 2)));
        checkOutput($sformatf("stream_instr%0d", c), instr, expData(10'(4 * (c - 2))));
      end
    end

    // Stall from cycle 0: four requests, then FIFO full
    doReset();
    releaseReset(1'b0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) applyStimulus(1'b0, 10'd0, 1'b0);
      checkOutput($sformatf("stall_req%0d", c), 32'(romReq), (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) checkOutput($sformatf("stall_addr%0d", c), 32'(romAddr), 32'(4 * c));
    end
    for (int c = 6; c < 11; c++) begin
      applyStimulus(1'b0, 10'd0, 1'b1);
      if (c == 6) checkOutput("drain_req6", 32'(romReq), 32'd0);
      if (c == 7) begin
        checkOutput("drain_req7",  32'(romReq),  32'd1);
        checkOutput("drain_addr7", 32'(romAddr), 32'd16);
      end
      checkOutput($sformatf("drain_valid%0d", c), 32'(valid),   32'd1);
      checkOutput($sformatf("drain_iaddr%0d", c), 32'(iduAddr), 32'(4 * (c - 6)));
      checkOutput($sformatf("drain_instr%0d", c), instr,        expData(10'(4 * (c - 6))));
    end

    // Redirect with three entries queued and one fetch in flight
    doReset();
    releaseReset(1'b0);
    for (int c = 1; c < 4; c++) applyStimulus(1'b0, 10'd0, 1'b0);
    applyStimulus(1'b1, 10'h100, 1'b1);
    checkOutput("jmp_validF", 32'(valid),  32'd0);
    checkOutput("jmp_reqF",   32'(romReq), 32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("jmp_reqF1",   32'(romReq),  32'd1);
    checkOutput("jmp_addrF1",  32'(romAddr), 32'h100);
    checkOutput("jmp_validF1", 32'(valid),   32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("jmp_validF2", 32'(valid), 32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("jmp_validF3", 32'(valid),   32'd1);
    checkOutput("jmp_iaddrF3", 32'(iduAddr), 32'h100);
    checkOutput("jmp_instrF3", instr,        expData(10'h100));
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("jmp_iaddrF4", 32'(iduAddr), 32'h104);

    // Back-to-back redirects (last wins) and PC wrap on the 6-bit unit
    applyStimulus(1'b1, 10'd20, 1'b1);
    applyStimulus(1'b1, 10'd60, 1'b1);
    checkOutput("wrap_validF", 32'(valid6), 32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("wrap_addrF1", 32'(romAddr6), 32'd60);
    applyStimulus(1'b0, 10'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 10'd0, 1'b1);
      checkOutput($sformatf("wrap_valid%0d", k), 32'(valid6), 32'd1);
      checkOutput($sformatf("wrap_iaddr%0d", k), 32'(iduAddr6), (k == 0) ? 32'd60 : 32'(4 * (k - 1)));
      checkOutput($sformatf("wrap_instr%0d", k), instr6,
                  expData((k == 0) ? 10'd60 : 10'(4 * (k - 1))));
    end

    // Random ready and redirects against a sequential-address model
    expNext   = '0;
    delivered = 0;
    maxCount  = 0;
    for (int i = 0; i < 1000; i++) begin
      j = (i == 0) || ($urandom_range(0, 99) < 5);
      a = {$urandom_range(0, 255) > 0 ? 8'($urandom_range(0, 255)) : 8'd0, 2'b00};
      r = 1'($urandom_range(0, 1));
      applyStimulus(j, a, r);
      if (int'(dut.count_q) > maxCount) maxCount = int'(dut.count_q);
      if (j) begin
        checkOutput("rnd_jumpValid", 32'(valid), 32'd0);
        expNext = a;
      end else if (valid && ready) begin
        checkOutput("rnd_iaddr", 32'(iduAddr), 32'(expNext));
        checkOutput("rnd_instr", instr,        expData(expNext));
        expNext = expNext + 10'd4;
        delivered++;
      end
    end
    checkOutput("rnd_countBound", 32'(maxCount <= 4), 32'd1);
    checkOutput("rnd_progress",   32'(delivered > 100), 32'd1);

    // Asynchronous reset in the middle of streaming with a fetch in flight
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 10'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    releaseReset(1'b1);
    checkOutput("midrst_c0addr", 32'(romAddr), 32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("midrst_c1valid", 32'(valid), 32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("midrst_c2valid", 32'(valid),   32'd1);
    checkOutput("midrst_c2iaddr", 32'(iduAddr), 32'd0);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkOutput("midrst_c3iaddr", 32'(iduAddr), 32'd4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with an internal PC, a fixed-latency ROM read port, and a DEPTH-entry prefetch FIFO feeding the IDU over a valid/ready handshake. Replaces the pass-through fetch stage: it generates its own sequential fetch addresses and absorbs IDU stalls without re-fetching. It also discards stale fetches on a redirect (jump, branch, or trap) from the execute stage. It sits between the ROM and the IDU.

## Interface
- ADDR_WIDTH, 10: instruction address width; the PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32: instruction width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- PC_STEP, 4: PC increment per fetch.
- RESET_ADDR, 0: PC value after reset.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- jump_en_i  in  1  redirect request, sampled each rising edge.
- jump_addr_i  in  ADDR_WIDTH  redirect target.
- rom_req_o  out  1  ROM read strobe.
- rom_addr_o  out  ADDR_WIDTH  ROM read address.
- rom_data_i  in  DATA_WIDTH  ROM read data; valid exactly one cycle after a cycle with rom_req_o=1.
- idu_valid_o  out  1  instruction available.
- idu_ready_i  in  1  IDU accepts the instruction.
- idu_instr_o  out  DATA_WIDTH  instruction at the FIFO head.
- idu_addr_o  out  ADDR_WIDTH  address of idu_instr_o.

## Operation
- State:
  - pc: next fetch address.
  - inflight: 1 bit; a request was issued last cycle.
  - inflight_addr: address of that request.
  - FIFO of {addr, instr}, with count of width clog2(DEPTH+1).
- Issue:
  - rom_req_o = !jump_en_i && (count + inflight < DEPTH).
  - rom_addr_o = pc. Both outputs are combinational from registers and jump_en_i.
  - On an issue edge: pc <= pc + PC_STEP (truncated to ADDR_WIDTH), inflight <= 1, inflight_addr <= pc. Otherwise inflight <= 0.
- Return:
  - While inflight=1 and no jump this cycle, push {inflight_addr, rom_data_i} at the edge.
  - The issue rule reserves a slot for the in-flight word, so the push never finds the FIFO full.
- Pop:
  - idu_valid_o = (count != 0) && !jump_en_i.
  - The head is removed on an edge where idu_valid_o && idu_ready_i.
  - A push and a pop in the same cycle leave count unchanged.
  - idu_instr_o and idu_addr_o reflect the head whenever count != 0. Their value is don't-care when the FIFO is empty.
- Redirect (jump_en_i=1 at an edge):
  - pc <= jump_addr_i, count <= 0, FIFO pointers <= 0, inflight <= 0.
  - The in-flight return word is dropped.
  - No issue and no pop occur in that cycle, whatever the value of idu_ready_i.
  - jump_en_i held high for several cycles keeps the unit flushed, and the last target wins.
- Reset (any time, including mid-fetch):
  - pc = RESET_ADDR, inflight = 0, count = 0, pointers = 0.
  - rom_req_o is then 1 with rom_addr_o = RESET_ADDR.
  - idu_valid_o = 0, idu_instr_o = 0, idu_addr_o = 0. FIFO storage is reset to 0.

## Timing
- Reset release before edge E0: the request for RESET_ADDR issues in cycle 0, the data is pushed at the end of cycle 1, and idu_valid_o=1 in cycle 2. Fetch-to-decode latency is 2 cycles.
- Redirect sampled in cycle F: target requested in F+1, pushed at the end of F+2, idu_valid_o=1 in F+3.
- Steady state with idu_ready_i=1: one instruction per cycle, in consecutive addresses.
- With idu_ready_i=0: the FIFO fills to DEPTH and rom_req_o drops once count + inflight = DEPTH.
- After a stall, the first pop frees a slot. rom_req_o rises in the following cycle, and throughput recovers without a bubble while count ≥ 2.
- PC wrap: pc = 2^ADDR_WIDTH − PC_STEP is followed by 0. No error is raised.

## Test plan
- Reset then ready=1, RESET_ADDR=0, ROM[a]=a^32'hA5A5_0000:
  - rom_addr_o sequences 0,4,8,….
  - First idu_valid_o in cycle 2 with idu_addr_o=0.
  - One instruction per cycle thereafter, with matching data.
- Hold idu_ready_i=0 from cycle 0, DEPTH=4:
  - Exactly 4 requests (addr 0..12), then rom_req_o=0 and count=4.
  - Release ready: addresses 0,4,8,12,16 delivered in order, no duplicates or gaps.
- jump_en_i=1 with jump_addr_i=0x100 in cycle F while the FIFO holds 3 entries and one fetch is in flight:
  - idu_valid_o=0 in F.
  - rom_addr_o=0x100 in F+1.
  - First delivered idu_addr_o=0x100 in F+3.
  - No pre-jump address ever appears at the output.
- Random idu_ready_i (50%) over 1000 cycles with random jumps at a 5% rate:
  - Delivered addresses are strictly sequential between redirects, and each run starts at its jump target.
  - count never exceeds DEPTH.
- rst_n asserted mid-stream with a fetch in flight:
  - All outputs show reset values immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_ADDR.
  - The old in-flight word is never pushed.
- ADDR_WIDTH=6, start at jump 60:
  - Delivered addresses 60, 0, 4 in order.
